// File: rtl/booth_mult_seq_pkg.sv
// Shared multdiv definitions: FSM state encoding, Booth step count and
// the Booth selector encoding taken from the low two product-register bits.
package booth_mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MULT_STEPS = 32;

  // {Q[0], Q-1}: 01 adds M, 10 subtracts M, 00/11 only shift
  typedef enum logic [1:0] {
    BOOTH_NOP0 = 2'b00,
    BOOTH_ADD  = 2'b01,
    BOOTH_SUB  = 2'b10,
    BOOTH_NOP1 = 2'b11
  } booth_sel_e;

endpackage

// File: rtl/booth_mult_seq_if.sv
// Operand/result bundle between the multdiv control logic (master) and the
// Booth multiplier (slave).
interface booth_mult_seq_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_mult;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_mult, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_mult, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/booth_mult_seq_product_reg65.sv
// Booth product register {A, Q, Q-1}: load-enabled flop bank with
// asynchronous active-low clear.
module product_reg65 #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] p_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_q <= '0;
    end else if (en_i) begin
      p_q <= d_i;
    end
  end

  assign q_o = p_q;
endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed radix-2 Booth multiplier: one add/sub-and-shift step per
// cycle, registered low word plus 32-bit signed overflow flag, one-cycle done pulse.
module booth_mult_seq
  import booth_mult_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  booth_mult_seq_if.slave bus
);
  localparam int PW    = 2 * WIDTH + 1;
  localparam int CNT_W = $clog2(MULT_STEPS + 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]        m_q;
  logic [WIDTH-1:0]        result_q;
  logic                    exc_q;
  logic [PW-1:0]           p_q, p_d;
  logic                    p_en, res_en;
  booth_sel_e              sel;
  logic                    sub;
  logic signed [WIDTH:0]   a_ext, m_ext, addend, sum;

  product_reg65 #(.W(PW)) u_preg (
    .clk   (clk),
    .reset (reset),
    .en_i  (p_en),
    .d_i   (p_d),
    .q_o   (p_q)
  );

  // One shared 33-bit adder: subtraction is ~M with carry-in, so M = -2^31 needs no special case
  assign sel = booth_sel_e'(p_q[1:0]);
  always_comb begin
    sub    = (sel == BOOTH_SUB);
    a_ext  = $signed({p_q[PW-1], p_q[PW-1:WIDTH+1]});
    m_ext  = $signed({m_q[WIDTH-1], m_q});
    addend = '0;
    if (sel == BOOTH_ADD || sel == BOOTH_SUB) begin
      addend = sub ? ~m_ext : m_ext;
    end
    sum = a_ext + addend + $signed({{WIDTH{1'b0}}, sub});
  end

  // A new start aborts whatever is in flight, including a pending DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    p_en    = 1'b0;
    res_en  = 1'b0;
    if (bus.ctrl_mult) begin
      p_d     = {{WIDTH{1'b0}}, bus.data_operandB, 1'b0};
      p_en    = 1'b1;
      cnt_d   = '0;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (cnt_q == CNT_W'(MULT_STEPS)) begin
            res_en  = 1'b1;
            state_d = DONE;
          end else begin
            p_d   = {sum, p_q[WIDTH:1]};
            p_en  = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      m_q      <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (bus.ctrl_mult) begin
        m_q <= bus.data_operandA;
      end
      if (res_en) begin
        result_q <= p_q[WIDTH:1];
        exc_q    <= (p_q[PW-1:WIDTH+1] != {WIDTH{p_q[WIDTH]}});
      end
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = (state_q == DONE);
  assign bus.busy           = (state_q != IDLE);
endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed corner products, restart,
// asynchronous reset abort and randomized operands against a 64-bit reference.
module tb_booth_mult_seq;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  booth_mult_seq_if #(.WIDTH(32)) bus ();

  booth_mult_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: full 64-bit signed product; overflow if it is not a sign-extended 32-bit value
  function automatic void ref_mult(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic e);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    r = p[31:0];
    e = (p != longint'($signed(p[31:0])));
  endfunction

  task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.ctrl_mult     = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clk);
    bus.ctrl_mult     = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  // Called at the negedge right after the accepting edge; returns the edge index of the pulse
  task automatic wait_rdy(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.data_resultRDY) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic exc, output int lat);
    pulse_start(a, b);
    wait_rdy(lat);
    res = bus.data_result;
    exc = bus.data_exception;
  endtask

  logic [31:0] dir_a   [6] = '{32'd3, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] dir_b   [6] = '{32'd5, 32'd6, 32'hFFFF_FFFA, 32'd2, 32'hFFFF_FFFF, 32'd1};
  logic [31:0] dir_res [6] = '{32'd15, 32'hFFFF_FFD6, 32'd42, 32'hFFFF_FFFE, 32'h8000_0000, 32'h8000_0000};
  logic        dir_exc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0001};

  initial begin
    logic [31:0] res, a, b, er;
    logic        exc, ee;
    int          lat, pulses;
    n_checks = 0;
    n_fail   = 0;
    reset             = 1'b0;
    bus.ctrl_mult     = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;

    repeat (3) @(negedge clk);
    check("reset_result", {32'd0, bus.data_result}, 64'd0);
    check("reset_exc", {63'd0, bus.data_exception}, 64'd0);
    check("reset_rdy", {63'd0, bus.data_resultRDY}, 64'd0);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(dir_a[i], dir_b[i], res, exc, lat);
      check($sformatf("dir%0d_latency", i), 64'(lat), 64'd33);
      check($sformatf("dir%0d_result", i), {32'd0, res}, {32'd0, dir_res[i]});
      check($sformatf("dir%0d_exc", i), {63'd0, exc}, {63'd0, dir_exc[i]});
      @(negedge clk);
      check($sformatf("dir%0d_rdy_after", i), {63'd0, bus.data_resultRDY}, 64'd0);
      check($sformatf("dir%0d_busy_after", i), {63'd0, bus.busy}, 64'd0);
      check($sformatf("dir%0d_hold", i), {32'd0, bus.data_result}, {32'd0, dir_res[i]});
    end

    // Restart at cycle 10: only the second operation may complete
    pulse_start(32'd100, 32'd100);
    pulses = 0;
    repeat (9) begin
      @(negedge clk);
      if (bus.data_resultRDY) pulses++;
    end
    bus.ctrl_mult     = 1'b1;
    bus.data_operandA = 32'd4;
    bus.data_operandB = 32'hFFFF_FFFD;
    @(negedge clk);
    bus.ctrl_mult = 1'b0;
    wait_rdy(lat);
    check("restart_early_pulses", 64'(pulses), 64'd0);
    check("restart_latency", 64'(lat), 64'd33);
    check("restart_result", {32'd0, bus.data_result}, {32'd0, 32'hFFFF_FFF4});

    // Asynchronous reset mid-operation
    pulse_start(32'd7, 32'd9);
    repeat (19) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("areset_result", {32'd0, bus.data_result}, 64'd0);
    check("areset_exc", {63'd0, bus.data_exception}, 64'd0);
    check("areset_rdy", {63'd0, bus.data_resultRDY}, 64'd0);
    check("areset_busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    reset  = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.data_resultRDY || bus.busy) pulses++;
    end
    check("areset_no_pulse", 64'(pulses), 64'd0);
    run_op(32'd2, 32'd2, res, exc, lat);
    check("post_reset_latency", 64'(lat), 64'd33);
    check("post_reset_result", {32'd0, res}, 64'd4);

    for (int i = 0; i < 1000; i++) begin
      a = ($urandom_range(7) == 0) ? corners[$urandom_range(5)] : $urandom;
      b = ($urandom_range(7) == 0) ? corners[$urandom_range(5)] : $urandom;
      ref_mult(a, b, er, ee);
      run_op(a, b, res, exc, lat);
      check($sformatf("rand%0d_latency %h*%h", i, a, b), 64'(lat), 64'd33);
      check($sformatf("rand%0d_result %h*%h", i, a, b), {32'd0, res}, {32'd0, er});
      check($sformatf("rand%0d_exc %h*%h", i, a, b), {63'd0, exc}, {63'd0, ee});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Sequential signed 32×32 radix-2 Booth multiplier for the processor's multdiv unit. Owns the 65-bit product register {A, Q, Q₋₁} and sequences it through 32 add/subtract-and-shift steps. Issues a one-cycle `result_ready` pulse to the stall/writeback logic. Reports overflow when the 64-bit product does not fit in 32 signed bits.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width. The product register is 2·WIDTH+1 bits. Only 32 is verified.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `ctrl_mult`  in  1  start pulse; operands are sampled on the same edge.
- `data_operandA`  in  32  multiplicand M, signed.
- `data_operandB`  in  32  multiplier, signed; loaded into Q.
- `data_result`  out  32  low 32 bits of the product.
- `data_exception`  out  1  overflow flag.
- `data_resultRDY`  out  1  one-cycle done pulse.
- `busy`  out  1  high while an operation is in flight.

## Operation
- States: IDLE, RUN, DONE.
- Reset values:
  - state = IDLE, product register = 0, M register = 0, step counter = 0.
  - All outputs = 0.
- IDLE, `ctrl_mult`=1:
  - M ← operandA.
  - P ← {32'b0, operandB, 1'b0}.
  - counter ← 0.
  - Go to RUN.
- RUN, one step per cycle, driven by P[1:0]:
  - 00/11: sum = A (sign-extended to 33 bits).
  - 01: sum = A + M (33-bit signed).
  - 10: sum = A − M (33-bit signed).
  - P ← {sum[32], sum[32:1], sum[0], Q[31:1], Q[0]}. This is an arithmetic shift right of {sum, Q, Q₋₁} that uses the 33-bit sum sign, so M = −2³¹ is correct.
  - counter increments. After the step with counter = 31, go to DONE.
- DONE:
  - `data_resultRDY` = 1 for exactly this cycle.
  - Go to IDLE.
- `data_result` = P[32:1], registered. It updates only on entry to DONE and holds until the next DONE.
- `data_exception` = 1 iff P[64:33] ≠ {32{P[32]}}, evaluated on the final product. It updates and holds with `data_result`.
- `busy` = 1 in RUN and DONE.
- `ctrl_mult` in RUN or DONE: abort, reload from the current operands, counter ← 0, stay in or enter RUN. No `data_resultRDY` is issued for the aborted operation. Restart has priority over the DONE pulse.
- `reset` low mid-operation: immediate return to IDLE with all registers cleared. The aborted operation produces no `data_resultRDY`.
- Operand inputs are ignored except on an accepted `ctrl_mult` edge.

## Timing
- Edge 0: `ctrl_mult` sampled.
- Edges 1–32: the 32 RUN steps.
- Edge 33: DONE state entered.
  - `data_resultRDY` high during the cycle after edge 33.
  - `data_result` and `data_exception` valid from edge 33 onward.
- Latency is 33 cycles from accept to `data_resultRDY`. Back-to-back starts are possible at the edge after DONE (34-cycle throughput), or earlier via restart.
- No combinational path from inputs to outputs.

## Structure
- Shared multdiv package:
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - `MULT_STEPS` = 32.
  - Booth selector encoding.
- One natural sub-module: `product_reg65`, a 65-bit enable/async-clear register holding {A, Q, Q₋₁}. The counter, M register, FSM and 33-bit add/sub stay in the top block.
- The 33-bit adder is a single add with conditional inversion of M and carry-in, shared between the add and subtract cases.

## Test plan
- 3 × 5 → `data_resultRDY` pulses exactly at cycle 33 after the start; result = 15, exception = 0, `busy` low one cycle later.
- −7 × 6 → result = 0xFFFFFFD6 (−42), exception = 0. Also −7 × −6 → 42.
- 0x7FFFFFFF × 2 → result = 0xFFFFFFFE, exception = 1. Also 0x80000000 × 0xFFFFFFFF → result = 0x80000000, exception = 1. Also 0x80000000 × 1 → exception = 0.
- Start 100 × 100, then at cycle 10 re-pulse `ctrl_mult` with 4 × −3 → single `data_resultRDY` 33 cycles after the second pulse, result = −12.
- Assert `reset` low asynchronously at cycle 20 of an operation → outputs 0 and state IDLE before the next edge; no pulse follows. A fresh 2 × 2 then completes with result 4.
- Random signed operands (≥1000), compared against a 64-bit reference product → low word and overflow flag match every time.
